// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel timer: channel modes and FSM states.
package timer_pkg;

   typedef enum logic [1:0] {
      MODE_ONESHOT = 2'b00,
      MODE_RELOAD  = 2'b01,
      MODE_FREERUN = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_EXPIRED = 2'b10
   } state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/EXPIRED FSM with latched mode and terminal count.
module timer_channel
   import timer_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic             clk_2K,
   input  logic             i_Reset,
   input  logic             i_Enable,
   input  logic             i_Start,
   input  logic             i_Clear,
   input  logic [1:0]       i_Mode,
   input  logic [WIDTH-1:0] i_Terminal,
   output logic [WIDTH-1:0] o_Count,
   output logic             o_Busy,
   output logic             o_Done,
   output logic             o_Expired
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           r_State;
   mode_e            r_Mode;
   logic [WIDTH-1:0] r_Term;
   logic [WIDTH-1:0] r_Count;
   logic             r_Done;
   logic             w_Hit;

   // Free-run ignores the latched terminal and wraps at all-ones.
   assign w_Hit = (r_Mode == MODE_FREERUN) ? (r_Count == {WIDTH{1'b1}})
                                           : (r_Count == r_Term);

   always_ff @(posedge clk_2K or negedge i_Reset) begin
      if (!i_Reset) begin
         r_State <= ST_IDLE;
         r_Mode  <= MODE_ONESHOT;
         r_Term  <= '0;
         r_Count <= '0;
         r_Done  <= 1'b0;
      end else begin
         r_Done <= 1'b0;
         if (i_Clear) begin
            r_State <= ST_IDLE;
            r_Count <= '0;
         end else if (i_Start) begin
            r_State <= ST_RUN;
            r_Count <= '0;
            r_Mode  <= mode_e'(i_Mode);
            r_Term  <= i_Terminal;
         end else if (r_State == ST_RUN && i_Enable) begin
            if (w_Hit) begin
               r_Done <= 1'b1;
               case (r_Mode)
                  MODE_RELOAD, MODE_FREERUN: r_Count <= '0;
                  default:                   r_State <= ST_EXPIRED;
               endcase
            end else begin
               r_Count <= r_Count + ONE;
            end
         end
      end
   end

   assign o_Count   = r_Count;
   assign o_Done    = r_Done;
   assign o_Busy    = (r_State == ST_RUN);
   assign o_Expired = (r_State == ST_EXPIRED);

endmodule

// File: rtl/multi_timer.sv
// Bank of CHANNELS independent timers sharing one tick enable.
module multi_timer
   import timer_pkg::*;
#(
   parameter int WIDTH    = 12,
   parameter int CHANNELS = 4
) (
   input  logic                      clk_2K,
   input  logic                      i_Reset,
   input  logic                      i_Enable,
   input  logic [CHANNELS-1:0]       i_Start,
   input  logic [CHANNELS-1:0]       i_Clear,
   input  logic [2*CHANNELS-1:0]     i_Mode,
   input  logic [WIDTH*CHANNELS-1:0] i_Terminal,
   output logic [WIDTH*CHANNELS-1:0] o_Count,
   output logic [CHANNELS-1:0]       o_Busy,
   output logic [CHANNELS-1:0]       o_Done,
   output logic [CHANNELS-1:0]       o_Expired
);

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      timer_channel #(.WIDTH(WIDTH)) u_ch (
         .clk_2K     (clk_2K),
         .i_Reset    (i_Reset),
         .i_Enable   (i_Enable),
         .i_Start    (i_Start[k]),
         .i_Clear    (i_Clear[k]),
         .i_Mode     (i_Mode[2*k +: 2]),
         .i_Terminal (i_Terminal[WIDTH*k +: WIDTH]),
         .o_Count    (o_Count[WIDTH*k +: WIDTH]),
         .o_Busy     (o_Busy[k]),
         .o_Done     (o_Done[k]),
         .o_Expired  (o_Expired[k])
      );
   end

endmodule

// File: tb/tb_multi_timer.sv
// Directed + random checks of multi_timer against an enabled-edge counting model.
module tb_multi_timer;

   localparam int W = 4;
   localparam int C = 4;

   logic           clk_2K   = 1'b0;
   logic           i_Reset  = 1'b0;
   logic           i_Enable = 1'b0;
   logic [C-1:0]   i_Start  = '0;
   logic [C-1:0]   i_Clear  = '0;
   logic [2*C-1:0] i_Mode   = '0;
   logic [W*C-1:0] i_Terminal = '0;
   logic [W*C-1:0] o_Count;
   logic [C-1:0]   o_Busy, o_Done, o_Expired;

   multi_timer #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk_2K(clk_2K), .i_Reset(i_Reset), .i_Enable(i_Enable),
      .i_Start(i_Start), .i_Clear(i_Clear), .i_Mode(i_Mode),
      .i_Terminal(i_Terminal), .o_Count(o_Count), .o_Busy(o_Busy),
      .o_Done(o_Done), .o_Expired(o_Expired)
   );

   always #5 clk_2K = ~clk_2K;

   // Model: a started channel is described only by enabled edges seen since start.
   bit         m_act  [C];
   int         m_n    [C];
   int         m_T    [C];
   logic [1:0] m_mode [C];
   bit         m_done [C];

   int n_chk  = 0;
   int n_fail = 0;

   function automatic bit m_oneshot(int k);
      return (m_mode[k] == 2'b00) || (m_mode[k] == 2'b11);
   endfunction

   function automatic int m_period(int k);
      return (m_mode[k] == 2'b10) ? (1 << W) : m_T[k] + 1;
   endfunction

   function automatic bit m_exp(int k);
      return m_act[k] && m_oneshot(k) && (m_n[k] >= m_period(k));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < C; k++) begin
         m_act[k] = 0; m_n[k] = 0; m_T[k] = 0; m_mode[k] = 2'b00; m_done[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < C; k++) begin
         m_done[k] = 0;
         if (i_Clear[k]) begin
            m_act[k] = 0; m_n[k] = 0;
         end else if (i_Start[k]) begin
            m_act[k] = 1; m_n[k] = 0;
            m_mode[k] = i_Mode[2*k +: 2];
            m_T[k] = int'(i_Terminal[W*k +: W]);
         end else if (m_act[k] && i_Enable && !m_exp(k)) begin
            m_n[k]++;
            m_done[k] = m_oneshot(k) ? (m_n[k] == m_period(k))
                                     : (m_n[k] % m_period(k) == 0);
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [W*C-1:0] e_cnt;
      logic [C-1:0]   e_busy, e_done, e_exp;
      int             v;
      e_cnt = '0; e_busy = '0; e_done = '0; e_exp = '0;
      for (int k = 0; k < C; k++) begin
         if (!m_act[k])        v = 0;
         else if (m_exp(k))    v = m_T[k];
         else if (m_oneshot(k)) v = m_n[k];
         else                  v = m_n[k] % m_period(k);
         e_cnt[W*k +: W] = W'(v);
         e_busy[k] = m_act[k] && !m_exp(k);
         e_exp[k]  = m_exp(k);
         e_done[k] = m_done[k];
      end
      chk({tag, "_count"},   32'(o_Count),   32'(e_cnt));
      chk({tag, "_busy"},    32'(o_Busy),    32'(e_busy));
      chk({tag, "_done"},    32'(o_Done),    32'(e_done));
      chk({tag, "_expired"}, 32'(o_Expired), 32'(e_exp));
   endtask

   task automatic step(input string tag);
      @(posedge clk_2K);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic set_ch(input int k, input logic st, input logic [1:0] md, input logic [W-1:0] t);
      i_Start[k] = st;
      i_Mode[2*k +: 2] = md;
      i_Terminal[W*k +: W] = t;
   endtask

   initial begin
      model_reset();
      #12;
      check_all("in_reset");
      @(negedge clk_2K);
      i_Reset = 1'b1;
      step("idle");

      // One-shot T=5 on ch0, reload T=2 on ch1, free-run on ch2, all started together
      set_ch(0, 1'b1, 2'b00, 4'd5);
      set_ch(1, 1'b1, 2'b01, 4'd2);
      set_ch(2, 1'b1, 2'b10, 4'd9);
      i_Enable = 1'b1;
      step("start");
      i_Start = '0;
      i_Mode = '1;
      i_Terminal = '0;
      for (int i = 0; i < 16; i++) begin
         step("run");
         if (i == 5) begin
            chk("ch0_done_6th", 32'(o_Done[0]), 32'd1);
            chk("ch0_hold_T",   32'(o_Count[3:0]), 32'd5);
         end
         if (i == 8) chk("ch1_done_9th", 32'(o_Done[1]), 32'd1);
         if (i == 15) chk("ch2_wrap_done", 32'(o_Done[2]), 32'd1);
      end
      chk("ch0_expired_level", 32'(o_Expired[0]), 32'd1);
      i_Enable = 1'b0;
      for (int i = 0; i < 3; i++) step("frozen");
      i_Enable = 1'b1;
      step("resume");

      // Start and clear on the same edge while RUN at count 3
      set_ch(0, 1'b1, 2'b00, 4'd9);
      step("restart");
      i_Start = '0;
      for (int i = 0; i < 3; i++) step("count3");
      chk("ch0_at3", 32'(o_Count[3:0]), 32'd3);
      i_Start[0] = 1'b1;
      i_Clear[0] = 1'b1;
      step("start_clear");
      chk("clear_wins_busy", 32'(o_Busy[0]), 32'd0);
      i_Start = '0;
      i_Clear = '0;

      // Start coinciding with a terminal edge
      set_ch(0, 1'b1, 2'b01, 4'd2);
      step("reload_start");
      i_Start = '0;
      step("r1");
      step("r2");
      i_Start[0] = 1'b1;
      step("start_on_term");
      chk("start_term_nodone", 32'(o_Done[0]), 32'd0);
      i_Start = '0;
      step("after_term");

      // Async reset mid-run at count 7, then T=0 start on first edge after release
      set_ch(0, 1'b1, 2'b00, 4'd12);
      step("long_start");
      i_Start = '0;
      for (int i = 0; i < 7; i++) step("to7");
      chk("ch0_at7", 32'(o_Count[3:0]), 32'd7);
      #3;
      i_Reset = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #20;
      @(negedge clk_2K);
      i_Reset = 1'b1;
      set_ch(0, 1'b1, 2'b00, 4'd0);
      i_Enable = 1'b1;
      step("rel_start");
      chk("rel_start_busy", 32'(o_Busy[0]), 32'd1);
      i_Start = '0;
      step("t0_edge");
      chk("t0_done", 32'(o_Done[0]), 32'd1);

      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < C; k++) begin
            set_ch(k, ($urandom % 8) == 0, 2'($urandom),
                   (($urandom % 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4)));
            i_Clear[k] = ($urandom % 20) == 0;
         end
         i_Enable = ($urandom % 8) != 0;
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
